// File: rtl/capture_sequencer_if.sv
// Control, trigger and status bundle between a run controller and capture_sequencer.
// Latency: none, wires only.
// Backpressure: none. All signals are level or one-cycle pulses with no handshake.
interface capture_sequencer_if #(
  parameter int SHOTS_W   = 8,
  parameter int HOLDOFF_W = 16
);
  // controller -> sequencer
  logic                 arm;
  logic                 abort;
  logic                 laser_trigger;
  logic                 capture_done;
  logic [SHOTS_W-1:0]   cfg_num_shots;
  logic [HOLDOFF_W-1:0] cfg_holdoff;

  // sequencer -> controller / capture buffer
  logic                 fifo_trigger;
  logic                 busy;
  logic                 run_done;
  logic                 timeout_err;
  logic [SHOTS_W-1:0]   shot_count;
  logic [7:0]           missed_triggers;
  logic [1:0]           state_out;

  modport master (
    output arm, abort, laser_trigger, capture_done, cfg_num_shots, cfg_holdoff,
    input  fifo_trigger, busy, run_done, timeout_err, shot_count, missed_triggers, state_out
  );

  modport slave (
    input  arm, abort, laser_trigger, capture_done, cfg_num_shots, cfg_holdoff,
    output fifo_trigger, busy, run_done, timeout_err, shot_count, missed_triggers, state_out
  );
endinterface

// File: rtl/capture_sequencer.sv
// Sequences laser-triggered frame captures: arm, wait for trigger, capture, holdoff, repeat.
// Latency: fifo_trigger one cycle after the trigger edge; run_done one cycle after the final capture_done.
// Backpressure: none. Triggers that arrive while busy capturing or holding off are counted and dropped.
module capture_sequencer #(
  parameter int SHOTS_W        = 8,
  parameter int HOLDOFF_W      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               aclk,
  input  logic               areset,
  capture_sequencer_if.slave bus
);

  // The timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_trig_d;
  logic                 w_trig_edge;

  logic [SHOTS_W-1:0]   r_num_shots;
  logic [HOLDOFF_W-1:0] r_holdoff;
  logic [SHOTS_W-1:0]   r_shot_count;
  logic [SHOTS_W-1:0]   w_shot_inc;
  logic [HOLDOFF_W-1:0] r_ho_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [7:0]           r_missed;

  logic                 r_fifo_trig;
  logic                 r_run_done;
  logic                 r_timeout_err;

  // Strobes produced by the next-state logic and consumed by the datapath registers.
  logic                 w_accept_arm;
  logic                 w_fire;
  logic                 w_done_take;
  logic                 w_last_frame;
  logic                 w_timeout;
  logic                 w_miss;
  logic                 w_enter_holdoff;

  // A trigger event is a rising edge of the trigger level, seen against last cycle's sample.
  assign w_trig_edge = bus.laser_trigger & ~r_trig_d;
  assign w_shot_inc  = r_shot_count + SHOTS_W'(1);

  // Delay register for trigger edge detection.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_trig_d <= 1'b0;
    end else begin
      r_trig_d <= bus.laser_trigger;
    end
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and event strobes; abort overrides every other event, including arm and capture_done.
  always_comb begin
    w_state_nxt     = r_state;
    w_accept_arm    = 1'b0;
    w_fire          = 1'b0;
    w_done_take     = 1'b0;
    w_last_frame    = 1'b0;
    w_timeout       = 1'b0;
    w_miss          = 1'b0;
    w_enter_holdoff = 1'b0;

    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.arm) begin
            w_accept_arm = 1'b1;
            w_state_nxt  = S_ARMED;
          end
        end

        S_ARMED: begin
          if (w_trig_edge) begin
            w_fire      = 1'b1;
            w_state_nxt = S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          w_miss = w_trig_edge;
          // A done arriving on the last allowed cycle still completes the frame.
          if (bus.capture_done) begin
            w_done_take = 1'b1;
            if ((r_num_shots != '0) && (w_shot_inc == r_num_shots)) begin
              w_last_frame = 1'b1;
              w_state_nxt  = S_IDLE;
            end else begin
              w_enter_holdoff = 1'b1;
              w_state_nxt     = S_HOLDOFF;
            end
          end else if (r_to_cnt == TO_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end

        S_HOLDOFF: begin
          w_miss = w_trig_edge;
          if (r_ho_cnt == '0) begin
            w_state_nxt = S_ARMED;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Run configuration is captured only when an arm is accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_num_shots <= '0;
      r_holdoff   <= '0;
    end else if (w_accept_arm) begin
      r_num_shots <= bus.cfg_num_shots;
      r_holdoff   <= bus.cfg_holdoff;
    end
  end

  // Registered single-cycle pulses toward the capture buffer and the controller.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_fifo_trig <= 1'b0;
      r_run_done  <= 1'b0;
    end else begin
      r_fifo_trig <= w_fire;
      r_run_done  <= w_last_frame;
    end
  end

  // Sticky timeout flag, cleared only by a new run.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_timeout_err <= 1'b0;
    end else if (w_accept_arm) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  // Completed-frame count for the current run; wraps naturally.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_shot_count <= '0;
    end else if (w_accept_arm) begin
      r_shot_count <= '0;
    end else if (w_done_take) begin
      r_shot_count <= w_shot_inc;
    end
  end

  // Dropped-trigger count, saturating so a noisy trigger cannot wrap it back to a small value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_missed <= '0;
    end else if (w_accept_arm) begin
      r_missed <= '0;
    end else if (w_miss && (r_missed != 8'hFF)) begin
      r_missed <= r_missed + 8'd1;
    end
  end

  // CAPTURE dwell counter, restarted on every entry into CAPTURE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_to_cnt <= '0;
    end else if (w_fire) begin
      r_to_cnt <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // HOLDOFF counter: loaded on entry, counts down to zero, then the FSM re-arms.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ho_cnt <= '0;
    end else if (w_enter_holdoff) begin
      r_ho_cnt <= r_holdoff;
    end else if ((r_state == S_HOLDOFF) && (r_ho_cnt != '0)) begin
      r_ho_cnt <= r_ho_cnt - HOLDOFF_W'(1);
    end
  end

  assign bus.fifo_trigger    = r_fifo_trig;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.run_done        = r_run_done;
  assign bus.timeout_err     = r_timeout_err;
  assign bus.shot_count      = r_shot_count;
  assign bus.missed_triggers = r_missed;
  assign bus.state_out       = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a per-cycle vector table plus multi-cycle scenarios.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
// A second instance with a short timeout covers the CAPTURE dwell limit.
module tb_capture_sequencer;

  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  capture_sequencer_if #(.SHOTS_W(8), .HOLDOFF_W(16)) bus ();
  capture_sequencer_if #(.SHOTS_W(8), .HOLDOFF_W(16)) bus_to ();

  capture_sequencer #(.SHOTS_W(8), .HOLDOFF_W(16), .TIMEOUT_CYCLES(4096)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  capture_sequencer #(.SHOTS_W(8), .HOLDOFF_W(16), .TIMEOUT_CYCLES(64)) dut_to (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus_to)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fifo_cnt = 0;
  int rd_cnt   = 0;

  // Pulse counters for the main instance, sampled mid-cycle.
  always @(negedge aclk) begin
    if (bus.fifo_trigger) fifo_cnt++;
    if (bus.run_done)     rd_cnt++;
  end

  typedef struct {
    logic       arm;
    logic       abort;
    logic       trig;
    logic       done;
    logic [7:0] shots;
    logic [15:0] ho;
    logic [1:0] st;
    logic       fifo;
    logic       rd;
    logic [7:0] shot;
    logic [7:0] miss;
    logic       err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic addv(input int a, input int ab, input int tr, input int dn,
                      input int sh, input int ho,
                      input int st, input int ff, input int rd,
                      input int sc, input int ms, input int er);
    vec_t v;
    v.arm = 1'(a);   v.abort = 1'(ab); v.trig = 1'(tr); v.done = 1'(dn);
    v.shots = 8'(sh); v.ho = 16'(ho);
    v.st = 2'(st);   v.fifo = 1'(ff); v.rd = 1'(rd);
    v.shot = 8'(sc); v.miss = 8'(ms); v.err = 1'(er);
    vq.push_back(v);
  endtask

  // Periodic-trigger run: trigger every 200 cycles, done 150 cycles after each fifo_trigger,
  // optionally one extra trigger edge 20 cycles into the first capture.
  task automatic run_sched(input int shots, input bit extra);
    int f0, r0, t_fifo, first, k;
    f0 = fifo_cnt; r0 = rd_cnt; t_fifo = -1000; first = -1000; k = 0;
    bus.cfg_num_shots = 8'(shots);
    bus.cfg_holdoff   = 16'd10;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int t = 0; t < 800; t++) begin
      bus.laser_trigger = ((t % 200) < 3) || (extra && (t == first + 20));
      bus.capture_done  = (t == t_fifo + 150);
      tick();
      if (bus.capture_done) begin
        k++;
        chk($sformatf("sched%0d_shot_count_frame%0d", shots, k), int'(bus.shot_count), k);
      end
      if (bus.fifo_trigger) begin
        t_fifo = t + 1;
        if (first < 0) first = t + 1;
      end
    end
    bus.laser_trigger = 1'b0;
    bus.capture_done  = 1'b0;
    chk($sformatf("sched%0d_fifo_pulses", shots), fifo_cnt - f0, shots);
    chk($sformatf("sched%0d_run_done_pulses", shots), rd_cnt - r0, 1);
    chk($sformatf("sched%0d_end_state", shots), int'(bus.state_out), 0);
    chk($sformatf("sched%0d_missed", shots), int'(bus.missed_triggers), extra ? 1 : 0);
  endtask

  initial begin
    int n, guard, f0, r0;

    bus.arm = 1'b0; bus.abort = 1'b0; bus.laser_trigger = 1'b0; bus.capture_done = 1'b0;
    bus.cfg_num_shots = '0; bus.cfg_holdoff = '0;
    bus_to.arm = 1'b0; bus_to.abort = 1'b0; bus_to.laser_trigger = 1'b0; bus_to.capture_done = 1'b0;
    bus_to.cfg_num_shots = '0; bus_to.cfg_holdoff = '0;

    // Reset values, before any clock edge has occurred.
    areset = 1'b1;
    #2;
    chk("rst_state", int'(bus.state_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_fifo_trigger", int'(bus.fifo_trigger), 0);
    chk("rst_run_done", int'(bus.run_done), 0);
    chk("rst_timeout_err", int'(bus.timeout_err), 0);
    chk("rst_shot_count", int'(bus.shot_count), 0);
    chk("rst_missed", int'(bus.missed_triggers), 0);
    tick(2);
    areset = 1'b0;
    tick();

    // arm ab trg dn shots ho | state fifo rd shot miss err
    addv(1, 0, 0, 0, 2, 1,   1, 0, 0, 0, 0, 0);  // arm latches shots=2 holdoff=1
    addv(0, 0, 0, 0, 2, 1,   1, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 2, 1,   2, 1, 0, 0, 0, 0);  // edge in ARMED -> fifo_trigger next cycle
    addv(0, 0, 1, 0, 7, 9,   2, 0, 0, 0, 0, 0);  // held level, no edge; cfg change ignored
    addv(0, 0, 0, 0, 7, 9,   2, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 2, 1,   2, 0, 0, 0, 1, 0);  // edge in CAPTURE is missed
    addv(0, 0, 0, 1, 2, 1,   3, 0, 0, 1, 1, 0);  // done -> HOLDOFF, count loaded with 1
    addv(0, 0, 1, 0, 2, 1,   3, 0, 0, 1, 2, 0);  // edge in HOLDOFF is missed
    addv(0, 0, 0, 0, 2, 1,   1, 0, 0, 1, 2, 0);  // holdoff expired -> ARMED
    addv(0, 0, 0, 1, 2, 1,   1, 0, 0, 1, 2, 0);  // done outside CAPTURE ignored
    addv(0, 0, 1, 0, 2, 1,   2, 1, 0, 1, 2, 0);
    addv(0, 0, 0, 1, 2, 1,   0, 0, 1, 2, 2, 0);  // final frame -> run_done, IDLE
    addv(0, 0, 0, 0, 2, 1,   0, 0, 0, 2, 2, 0);
    addv(1, 0, 0, 0, 2, 1,   1, 0, 0, 0, 0, 0);  // new arm clears counters
    addv(0, 1, 1, 0, 2, 1,   0, 0, 0, 0, 0, 0);  // abort beats trigger edge
    addv(0, 0, 0, 0, 2, 1,   0, 0, 0, 0, 0, 0);
    addv(1, 1, 0, 0, 2, 1,   0, 0, 0, 0, 0, 0);  // abort beats arm
    addv(1, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0);  // arm with shots=1
    addv(0, 0, 1, 0, 5, 0,   2, 1, 0, 0, 0, 0);  // cfg change outside arm ignored
    addv(1, 0, 0, 0, 5, 0,   2, 0, 0, 0, 0, 0);  // arm outside IDLE ignored
    addv(0, 0, 0, 1, 5, 0,   0, 0, 1, 1, 0, 0);  // latched shots=1 -> run complete
    addv(0, 0, 0, 0, 5, 0,   0, 0, 0, 1, 0, 0);

    foreach (vq[i]) begin
      bus.arm = vq[i].arm; bus.abort = vq[i].abort;
      bus.laser_trigger = vq[i].trig; bus.capture_done = vq[i].done;
      bus.cfg_num_shots = vq[i].shots; bus.cfg_holdoff = vq[i].ho;
      tick();
      chk($sformatf("vec%0d_state", i), int'(bus.state_out), int'(vq[i].st));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), (vq[i].st != 2'd0) ? 1 : 0);
      chk($sformatf("vec%0d_fifo_trigger", i), int'(bus.fifo_trigger), int'(vq[i].fifo));
      chk($sformatf("vec%0d_run_done", i), int'(bus.run_done), int'(vq[i].rd));
      chk($sformatf("vec%0d_shot_count", i), int'(bus.shot_count), int'(vq[i].shot));
      chk($sformatf("vec%0d_missed", i), int'(bus.missed_triggers), int'(vq[i].miss));
      chk($sformatf("vec%0d_timeout_err", i), int'(bus.timeout_err), int'(vq[i].err));
    end
    bus.arm = 1'b0; bus.abort = 1'b0; bus.laser_trigger = 1'b0; bus.capture_done = 1'b0;
    tick();

    // Three-shot run and two-shot run with an extra trigger inside CAPTURE.
    run_sched(3, 1'b0);
    run_sched(2, 1'b1);

    // Timeout on the short-timeout instance: 64 CAPTURE cycles, then IDLE with the error set.
    bus_to.cfg_num_shots = 8'd0; bus_to.cfg_holdoff = 16'd0;
    bus_to.arm = 1'b1; tick(); bus_to.arm = 1'b0;
    bus_to.laser_trigger = 1'b1; tick(); bus_to.laser_trigger = 1'b0;
    n = 0; guard = 0;
    while ((bus_to.state_out == 2'd2) && (guard < 200)) begin
      n++; guard++;
      tick();
    end
    chk("timeout_capture_cycles", n, 64);
    chk("timeout_err_set", int'(bus_to.timeout_err), 1);
    chk("timeout_state_idle", int'(bus_to.state_out), 0);
    chk("timeout_shot_holds", int'(bus_to.shot_count), 0);
    bus_to.arm = 1'b1; tick(); bus_to.arm = 1'b0;
    chk("timeout_err_cleared_by_arm", int'(bus_to.timeout_err), 0);
    // Done on the final allowed CAPTURE cycle wins over the timeout.
    bus_to.laser_trigger = 1'b1; tick(); bus_to.laser_trigger = 1'b0;
    tick(63);
    chk("late_done_still_capture", int'(bus_to.state_out), 2);
    bus_to.capture_done = 1'b1; tick(); bus_to.capture_done = 1'b0;
    chk("late_done_state_holdoff", int'(bus_to.state_out), 3);
    chk("late_done_no_err", int'(bus_to.timeout_err), 0);
    chk("late_done_shot", int'(bus_to.shot_count), 1);
    bus_to.abort = 1'b1; tick(); bus_to.abort = 1'b0;

    // Free-running run (shots=0, holdoff=0): five frames, then abort in HOLDOFF.
    r0 = rd_cnt;
    bus.cfg_num_shots = 8'd0; bus.cfg_holdoff = 16'd0;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.laser_trigger = 1'b1; tick(); bus.laser_trigger = 1'b0;
      tick(3);
      bus.capture_done = 1'b1; tick(); bus.capture_done = 1'b0;
      chk($sformatf("free_frame%0d_holdoff", i), int'(bus.state_out), 3);
      if (i < 4) begin
        tick();
        chk($sformatf("free_frame%0d_rearmed", i), int'(bus.state_out), 1);
      end
    end
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("free_abort_idle", int'(bus.state_out), 0);
    chk("free_abort_shot_count", int'(bus.shot_count), 5);
    chk("free_no_run_done", rd_cnt - r0, 0);

    // Asynchronous reset while fifo_trigger is high in CAPTURE.
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    bus.laser_trigger = 1'b1; tick(); bus.laser_trigger = 1'b0;
    tick(2);
    bus.capture_done = 1'b1; tick(); bus.capture_done = 1'b0;
    tick();
    bus.laser_trigger = 1'b1; tick(); bus.laser_trigger = 1'b0;
    chk("pre_rst_state", int'(bus.state_out), 2);
    chk("pre_rst_fifo", int'(bus.fifo_trigger), 1);
    chk("pre_rst_shot", int'(bus.shot_count), 1);
    r0 = rd_cnt;
    #2;
    areset = 1'b1;
    #1;
    chk("async_rst_state", int'(bus.state_out), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_fifo", int'(bus.fifo_trigger), 0);
    chk("async_rst_shot", int'(bus.shot_count), 0);
    @(negedge aclk);
    areset = 1'b0;
    tick();
    bus.capture_done = 1'b1; tick(); bus.capture_done = 1'b0;
    tick();
    chk("post_rst_done_ignored_state", int'(bus.state_out), 0);
    chk("post_rst_done_ignored_shot", int'(bus.shot_count), 0);
    chk("post_rst_no_run_done", rd_cnt - r0, 0);

    // Held trigger gives one capture; 300 edges in HOLDOFF saturate the missed count.
    f0 = fifo_cnt;
    bus.cfg_num_shots = 8'd0; bus.cfg_holdoff = 16'd700;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    bus.laser_trigger = 1'b1; tick(50); bus.laser_trigger = 1'b0;
    chk("held_trig_one_fifo", fifo_cnt - f0, 1);
    chk("held_trig_capture", int'(bus.state_out), 2);
    chk("held_trig_no_miss", int'(bus.missed_triggers), 0);
    bus.capture_done = 1'b1; tick(); bus.capture_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.laser_trigger = 1'b1; tick();
      bus.laser_trigger = 1'b0; tick();
    end
    chk("sat_still_holdoff", int'(bus.state_out), 3);
    chk("sat_missed_255", int'(bus.missed_triggers), 255);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("sat_abort_idle", int'(bus.state_out), 0);
    chk("sat_abort_missed_holds", int'(bus.missed_triggers), 255);
    chk("sat_fifo_total", fifo_cnt - f0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
